d_task_beat_arbiter: RTL and testbench

- Shares the downstream two-stage task pipeline between NUM_REQ requesters (MSHR grant/release-ack task sources).
- Arbitrates round-robin, captures one task, and sequences it into 1 or BEATS pipeline beats, driving beat/last/needPb/counter.
- The grant stays locked to the winning task until its last beat is accepted. Sits directly upstream of the pipeline's io_in port.

---
 rtl/d_task_beat_arbiter.sv | 149 ++++++++++++++
 tb/tb_d_task_beat_arbiter.sv | 427 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/d_task_beat_arbiter.sv
// Round-robin arbiter that shares the two-stage task pipeline between several
// MSHR task sources. It captures one task and plays it out as 1 or BEATS beats.
// The grant stays locked to that task until its last beat is accepted.
module d_task_beat_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned BEATS   = 2,
    parameter int unsigned BEAT_W  = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    in_valid,
    output logic [NUM_REQ-1:0]    in_ready,
    input  logic [NUM_REQ*36-1:0] in_task,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_counter,
    output logic [BEAT_W-1:0]     out_beat,
    output logic                  out_last,
    output logic                  out_needPb,
    output logic                  out_isReleaseAck,
    output logic [5:0]            out_req_sourceId,
    output logic [9:0]            out_req_set,
    output logic [2:0]            out_req_opcode,
    output logic [2:0]            out_req_param,
    output logic [2:0]            out_req_size,
    output logic [2:0]            out_req_way,
    output logic                  out_req_denied,
    output logic [3:0]            out_req_sinkId,
    output logic                  out_req_dirty
);

    localparam int unsigned TASK_W = 36;
    localparam int unsigned PTR_W  = $clog2(NUM_REQ);
    localparam logic [BEAT_W-1:0] LAST_DATA_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [PTR_W-1:0]  LAST_REQ       = PTR_W'(NUM_REQ - 1);

    typedef enum logic [0:0] {StIdle, StBusy} state_e;

    state_e              state_q;
    logic [TASK_W-1:0]   task_q;
    logic [BEAT_W-1:0]   beat_q;
    logic [PTR_W-1:0]    ptr_q;
    logic                counter_q;

    logic                busy;
    logic                has_data;
    logic                is_rel_ack;
    logic                last_beat;
    logic                fire;
    logic                accept_ok;
    logic                any_valid;
    logic                accept;
    logic                found;
    logic [PTR_W-1:0]    scan_idx;
    logic [PTR_W-1:0]    winner;
    logic [PTR_W-1:0]    ptr_next;
    logic [NUM_REQ-1:0]  grant_oh;
    logic [TASK_W-1:0]   win_task;

    // Decode the held task and the beat handshake.
    always_comb begin
        busy       = (state_q == StBusy);
        has_data   = task_q[0];
        is_rel_ack = task_q[1];
        // A single-beat task only ever sits at beat 0, so its last beat is 0.
        last_beat  = (beat_q == (has_data ? LAST_DATA_BEAT : '0));
        fire       = busy & out_ready;
        // Either nothing is held, or the held task is finishing this cycle.
        accept_ok  = ~busy | (fire & last_beat);
        any_valid  = |in_valid;
    end

    // Round-robin scan: first valid requester at or after ptr, wrapping.
    always_comb begin
        found    = 1'b0;
        winner   = '0;
        scan_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan_idx = PTR_W'((32'(ptr_q) + k) % NUM_REQ);
            if (!found && in_valid[scan_idx]) begin
                found  = 1'b1;
                winner = scan_idx;
            end
        end
        ptr_next = (winner == LAST_REQ) ? '0 : winner + PTR_W'(1);
    end

    // One-hot grant and the task it selects.
    always_comb begin
        grant_oh = '0;
        win_task = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (winner == PTR_W'(i)) begin
                grant_oh[i] = 1'b1;
                win_task    = in_task[i*TASK_W +: TASK_W];
            end
        end
    end

    // Grant is gated by reset so nothing is offered while reset is held.
    always_comb begin
        accept   = accept_ok & any_valid & found & reset;
        in_ready = accept ? grant_oh : '0;
    end

    // Task FSM: capture on accept, step beats on fire, drop back to idle when done.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            task_q    <= '0;
            beat_q    <= '0;
            ptr_q     <= '0;
            counter_q <= 1'b0;
        end else if (accept) begin
            // Also covers back-to-back: the last beat fires in this same cycle.
            state_q   <= StBusy;
            task_q    <= win_task;
            beat_q    <= '0;
            ptr_q     <= ptr_next;
            counter_q <= ~counter_q;
        end else if (fire) begin
            if (last_beat) begin
                state_q <= StIdle;
            end else begin
                beat_q <= beat_q + BEAT_W'(1);
            end
        end
    end

    // Drive the pipeline beat from the held task.
    always_comb begin
        out_valid        = busy;
        out_counter      = counter_q;
        out_beat         = beat_q;
        out_last         = busy & last_beat;
        out_needPb       = busy & has_data & ~is_rel_ack;
        out_req_sourceId = task_q[35:30];
        out_req_set      = task_q[29:20];
        out_req_opcode   = task_q[19:17];
        out_req_param    = task_q[16:14];
        out_req_size     = task_q[13:11];
        out_req_way      = task_q[10:8];
        out_req_denied   = task_q[7];
        out_req_sinkId   = task_q[6:3];
        out_req_dirty    = task_q[2];
        out_isReleaseAck = is_rel_ack;
    end

endmodule

// File: tb/tb_d_task_beat_arbiter.sv
// Self-checking bench for d_task_beat_arbiter: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_d_task_beat_arbiter;

    localparam int NUM_REQ = 3;
    localparam int BEATS   = 2;
    localparam int BEAT_W  = 1;

    logic                  clock = 1'b0;
    logic                  reset = 1'b0;
    logic [NUM_REQ-1:0]    in_valid = '0;
    logic [NUM_REQ-1:0]    in_ready;
    logic [NUM_REQ*36-1:0] in_task = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic                  out_counter;
    logic [BEAT_W-1:0]     out_beat;
    logic                  out_last;
    logic                  out_needPb;
    logic                  out_isReleaseAck;
    logic [5:0]            out_req_sourceId;
    logic [9:0]            out_req_set;
    logic [2:0]            out_req_opcode;
    logic [2:0]            out_req_param;
    logic [2:0]            out_req_size;
    logic [2:0]            out_req_way;
    logic                  out_req_denied;
    logic [3:0]            out_req_sinkId;
    logic                  out_req_dirty;
    logic [34:0]           out_fields;

    int checks = 0;
    int errors = 0;

    d_task_beat_arbiter #(
        .NUM_REQ(NUM_REQ),
        .BEATS  (BEATS),
        .BEAT_W (BEAT_W)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_task         (in_task),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_counter     (out_counter),
        .out_beat        (out_beat),
        .out_last        (out_last),
        .out_needPb      (out_needPb),
        .out_isReleaseAck(out_isReleaseAck),
        .out_req_sourceId(out_req_sourceId),
        .out_req_set     (out_req_set),
        .out_req_opcode  (out_req_opcode),
        .out_req_param   (out_req_param),
        .out_req_size    (out_req_size),
        .out_req_way     (out_req_way),
        .out_req_denied  (out_req_denied),
        .out_req_sinkId  (out_req_sinkId),
        .out_req_dirty   (out_req_dirty)
    );

    always #5 clock = ~clock;

    // Task bits [35:1] in packing order, to compare against a task word.
    assign out_fields = {out_req_sourceId, out_req_set, out_req_opcode, out_req_param,
                         out_req_size, out_req_way, out_req_denied, out_req_sinkId,
                         out_req_dirty, out_isReleaseAck};

    function automatic logic [35:0] mk(input logic [5:0] src, input logic [9:0] set,
                                       input logic rel, input logic hd);
        mk = {src, set, src[2:0], ~src[2:0], set[2:0], set[5:3], src[0], set[9:6],
              src[1], rel, hd};
    endfunction

    task automatic set_req(input int i, input logic [35:0] t);
        in_task[i*36 +: 36] = t;
    endtask

    task automatic apply_reset();
        reset     = 1'b0;
        in_valid  = '0;
        out_ready = 1'b0;
        in_task   = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [35:0] t0;
        t0 = mk(6'h01, 10'h001, 1'b0, 1'b0);
        reset = 1'b0;
        set_req(0, t0);
        set_req(1, mk(6'h02, 10'h002, 1'b0, 1'b1));
        set_req(2, mk(6'h03, 10'h003, 1'b1, 1'b0));
        in_valid  = 3'b111;
        out_ready = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if ({out_valid, in_ready, out_beat, out_last, out_needPb, out_counter, out_fields} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got valid=%b ready=%b beat=%b last=%b pb=%b cnt=%b f=%h expected all 0",
                     out_valid, in_ready, out_beat, out_last, out_needPb, out_counter, out_fields);
        end
        @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        checks++;
        if (in_ready !== 3'b001) begin
            errors++;
            $display("FAIL reset_first_grant: got %b expected 001", in_ready);
        end
        @(posedge clock);
        #1 in_valid = '0;
        @(negedge clock);
        checks++;
        if ({out_valid, out_counter, out_last, out_fields} !== {1'b1, 1'b1, 1'b1, t0[35:1]}) begin
            errors++;
            $display("FAIL reset_first_beat: got v=%b c=%b l=%b f=%h expected 1 1 1 %h",
                     out_valid, out_counter, out_last, out_fields, t0[35:1]);
        end
        out_ready = 1'b1;
        @(posedge clock);
        #1 out_ready = 1'b0;
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_back_to_idle: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_data_task();
        logic [35:0] t;
        apply_reset();
        t = mk(6'h15, 10'h2A3, 1'b0, 1'b1);
        set_req(1, t);
        in_valid  = 3'b010;
        out_ready = 1'b1;
        @(negedge clock);
        checks++;
        if (in_ready !== 3'b010) begin
            errors++;
            $display("FAIL data_grant: got %b expected 010", in_ready);
        end
        @(posedge clock);
        #1 in_valid = '0;
        for (int b = 0; b < BEATS; b++) begin
            @(negedge clock);
            checks++;
            if ({out_valid, out_beat, out_last, out_needPb} !== {1'b1, BEAT_W'(b), b == BEATS - 1, 1'b1}) begin
                errors++;
                $display("FAIL data_beat%0d: got v=%b beat=%b last=%b pb=%b", b,
                         out_valid, out_beat, out_last, out_needPb);
            end
            checks++;
            if ({out_req_sourceId, out_req_set, out_fields} !== {6'h15, 10'h2A3, t[35:1]}) begin
                errors++;
                $display("FAIL data_fields%0d: got %h/%h/%h expected 15/2a3/%h", b,
                         out_req_sourceId, out_req_set, out_fields, t[35:1]);
            end
            @(posedge clock);
            #1;
        end
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL data_idle: got %b expected 0", out_valid);
        end
    endtask

    task automatic test_round_robin();
        apply_reset();
        for (int i = 0; i < NUM_REQ; i++) set_req(i, mk(6'(i + 8), 10'(i), 1'b0, 1'b0));
        in_valid  = 3'b111;
        out_ready = 1'b1;
        for (int k = 0; k < 7; k++) begin
            @(negedge clock);
            checks++;
            if (in_ready !== 3'(1 << (k % NUM_REQ))) begin
                errors++;
                $display("FAIL rr_grant%0d: got %b expected %b", k, in_ready, 3'(1 << (k % NUM_REQ)));
            end
            checks++;
            if (k > 0) begin
                if ({out_valid, out_last, out_counter, out_req_sourceId} !==
                    {1'b1, 1'b1, k[0], 6'((k - 1) % NUM_REQ + 8)}) begin
                    errors++;
                    $display("FAIL rr_beat%0d: got v=%b l=%b c=%b src=%h", k, out_valid, out_last,
                             out_counter, out_req_sourceId);
                end
            end else if (out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rr_idle_start: got %b expected 0", out_valid);
            end
            @(posedge clock);
            #1;
        end
        in_valid = '0;
    endtask

    task automatic test_stall();
        logic [35:0] td;
        logic [35:0] ts;
        apply_reset();
        td = mk(6'h21, 10'h155, 1'b0, 1'b1);
        ts = mk(6'h32, 10'h0F0, 1'b0, 1'b0);
        set_req(0, td);
        set_req(2, ts);
        in_valid  = 3'b001;
        out_ready = 1'b1;
        @(posedge clock);
        #1 in_valid = 3'b100;
        @(negedge clock);
        checks++;
        if ({in_ready, out_valid, out_beat} !== {3'b000, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL stall_beat0: got ready=%b v=%b beat=%b expected 000 1 0",
                     in_ready, out_valid, out_beat);
        end
        @(posedge clock);
        #1 out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clock);
            checks++;
            if ({in_ready, out_valid, out_beat, out_last, out_fields} !== {3'b000, 3'b111, td[35:1]}) begin
                errors++;
                $display("FAIL stall_hold%0d: got ready=%b v=%b beat=%b l=%b f=%h", s, in_ready,
                         out_valid, out_beat, out_last, out_fields);
            end
            @(posedge clock);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clock);
        checks++;
        if (in_ready !== 3'b100) begin
            errors++;
            $display("FAIL stall_release_grant: got %b expected 100", in_ready);
        end
        @(posedge clock);
        #1 in_valid = '0;
        @(negedge clock);
        checks++;
        if ({out_valid, out_beat, out_last, out_counter, out_fields} !== {4'b1010, ts[35:1]}) begin
            errors++;
            $display("FAIL stall_next_task: got v=%b beat=%b l=%b c=%b f=%h expected 1 0 1 0 %h",
                     out_valid, out_beat, out_last, out_counter, out_fields, ts[35:1]);
        end
        @(posedge clock);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_release_ack();
        logic [35:0] t;
        apply_reset();
        t = mk(6'h3F, 10'h3FF, 1'b1, 1'b0);
        set_req(0, t);
        in_valid  = 3'b001;
        out_ready = 1'b0;
        @(posedge clock);
        #1 in_valid = '0;
        for (int s = 0; s < 2; s++) begin
            @(negedge clock);
            checks++;
            if ({out_valid, out_beat, out_last, out_needPb, out_isReleaseAck, out_fields} !==
                {5'b10101, t[35:1]}) begin
                errors++;
                $display("FAIL relack_beat%0d: got v=%b beat=%b l=%b pb=%b ra=%b f=%h", s, out_valid,
                         out_beat, out_last, out_needPb, out_isReleaseAck, out_fields);
            end
            @(posedge clock);
            #1 out_ready = 1'b1;
        end
        out_ready = 1'b0;
        @(negedge clock);
        checks++;
        if ({out_valid, in_ready} !== 4'b0000) begin
            errors++;
            $display("FAIL relack_idle: got v=%b ready=%b expected 0 000", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [35:0] t;
        apply_reset();
        t = mk(6'h2B, 10'h111, 1'b0, 1'b1);
        set_req(1, t);
        in_valid  = 3'b010;
        out_ready = 1'b0;
        @(posedge clock);
        #1;
        @(negedge clock);
        checks++;
        if ({out_valid, out_beat, in_ready} !== {1'b1, 1'b0, 3'b000}) begin
            errors++;
            $display("FAIL midrst_busy: got v=%b beat=%b ready=%b", out_valid, out_beat, in_ready);
        end
        #1 reset = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, out_counter} !== 5'b00000) begin
            errors++;
            $display("FAIL midrst_drop: got v=%b ready=%b c=%b expected 0", out_valid, in_ready,
                     out_counter);
        end
        @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        checks++;
        if ({in_ready, out_valid} !== {3'b010, 1'b0}) begin
            errors++;
            $display("FAIL midrst_regrant: got ready=%b v=%b expected 010 0", in_ready, out_valid);
        end
        @(posedge clock);
        #1 in_valid = '0;
        @(negedge clock);
        checks++;
        if ({out_valid, out_beat, out_counter, out_fields} !== {3'b101, t[35:1]}) begin
            errors++;
            $display("FAIL midrst_reaccept: got v=%b beat=%b c=%b f=%h", out_valid, out_beat,
                     out_counter, out_fields);
        end
    endtask

    // Model: a held task is just "which task, how many beats remain"; the grant
    // is the first valid requester scanning from the round-robin pointer.
    task automatic test_random();
        logic [35:0]        pend [NUM_REQ];
        logic [35:0]        m_task;
        logic [63:0]        r;
        logic [NUM_REQ-1:0] exp_ready;
        int                 m_ptr;
        int                 m_left;
        int                 m_cnt;
        int                 grant;
        int                 cnt;
        int                 idx;
        bit                 m_busy;
        bit                 exp_fire;
        bit                 exp_last;
        bit                 ok;
        apply_reset();
        m_task = '0;
        m_ptr  = 0;
        m_left = 0;
        m_cnt  = 0;
        m_busy = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) pend[i] = '0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!in_valid[i] && $urandom_range(0, 2) == 0) begin
                    r       = {$urandom, $urandom};
                    pend[i] = r[35:0];
                    set_req(i, pend[i]);
                    in_valid[i] = 1'b1;
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clock);
            cnt      = m_task[0] ? BEATS : 1;
            exp_last = m_busy && (m_left == 1);
            exp_fire = m_busy && out_ready;
            ok       = !m_busy || (exp_fire && exp_last);
            grant    = -1;
            if (ok) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    idx = (m_ptr + k) % NUM_REQ;
                    if (grant < 0 && in_valid[idx]) grant = idx;
                end
            end
            exp_ready = (grant >= 0) ? NUM_REQ'(1 << grant) : '0;
            checks++;
            if ({in_ready, out_valid, out_counter} !== {exp_ready, m_busy, m_cnt[0]}) begin
                errors++;
                $display("FAIL rand_ctrl c%0d: got ready=%b v=%b cnt=%b expected %b %b %b", c,
                         in_ready, out_valid, out_counter, exp_ready, m_busy, m_cnt[0]);
            end
            if (m_busy) begin
                checks++;
                if ({out_beat, out_last, out_needPb, out_fields} !==
                    {BEAT_W'(cnt - m_left), exp_last, m_task[0] & ~m_task[1], m_task[35:1]}) begin
                    errors++;
                    $display("FAIL rand_beat c%0d: got beat=%b l=%b pb=%b f=%h expected %0d %b %b %h",
                             c, out_beat, out_last, out_needPb, out_fields, cnt - m_left, exp_last,
                             m_task[0] & ~m_task[1], m_task[35:1]);
                end
            end
            @(posedge clock);
            #1;
            if (exp_fire) begin
                m_left--;
                if (m_left == 0) m_busy = 1'b0;
            end
            if (grant >= 0) begin
                m_task = pend[grant];
                m_busy = 1'b1;
                m_left = m_task[0] ? BEATS : 1;
                m_ptr  = (grant + 1) % NUM_REQ;
                m_cnt  = m_cnt ^ 1;
                in_valid[grant] = 1'b0;
            end
        end
        in_valid  = '0;
        out_ready = 1'b0;
    endtask

    initial begin
        test_reset();
        test_data_task();
        test_round_robin();
        test_stall();
        test_release_ack();
        test_reset_mid_burst();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
